// File: rtl/tc_crc_pkg.sv
// Shared definitions for the telecommand/telemetry CRC-32 blocks.
// CRC flavour is CRC-32/MPEG-2: poly 0x04C11DB7, init 0xFFFFFFFF,
// MSB-first bit order, no reflection, no final XOR. Because there is no
// final XOR, running a frame plus its own CRC bytes through the register
// leaves a zero residue, which is what the receiver checks for.
package tc_crc_pkg;

  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam int          CRC_LEN  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } state_t;

  // One byte of CRC update, d[7] shifted in first.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ d[i];
      c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
    end
    return c;
  endfunction

endpackage

// File: rtl/tc_crc32_check_if.sv
// Byte-stream bundle between the deframer, the CRC checker and the
// telecommand frame buffer.
//   En_DataI/DataI      : incoming byte stream (payload followed by 4 CRC bytes)
//   En_DataO/DataO      : forwarded payload bytes
//   Frame_Done/Crc_Ok   : end-of-frame pulse and held verdict
//   Frame_Abort         : pulse when a partial frame is dropped on timeout
// master = producer of the input stream / consumer of results,
// slave  = the checker.
interface tc_crc32_check_if;

  logic       En_DataI;
  logic [7:0] DataI;
  logic       En_DataO;
  logic [7:0] DataO;
  logic       Frame_Done;
  logic       Crc_Ok;
  logic       Frame_Abort;

  modport master (
    output En_DataI, DataI,
    input  En_DataO, DataO, Frame_Done, Crc_Ok, Frame_Abort
  );

  modport slave (
    input  En_DataI, DataI,
    output En_DataO, DataO, Frame_Done, Crc_Ok, Frame_Abort
  );

endinterface

// File: rtl/tc_crc32_check_crc.sv
// Purely combinational byte-wide CRC-32/MPEG-2 next-state logic.
// Shared between the TM appender and the TC checker.
//   crc_i  : current CRC register
//   data_i : byte to absorb (bit 7 first)
//   crc_o  : CRC register after absorbing data_i
module crc32_d8_comb
  import tc_crc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = crc32_d8(crc_i, data_i);

endmodule

// File: rtl/tc_crc32_check.sv
// Receive-side CRC-32 checker for telecommand frames.
// Accepts DATA_LEN payload bytes followed by 4 CRC bytes (MSB byte first),
// forwards the payload with one cycle of latency, strips the CRC and
// reports a pass/fail verdict per frame. Frames stalled mid-way for
// TIMEOUT idle cycles are dropped. Good/bad frame counters saturate.
//   ClkI_Dec8 : byte clock
//   Rst_N     : asynchronous active-low reset
//   bus       : byte stream in / payload out / frame status (slave side)
//   Clr_Cnt   : synchronous clear of both counters, wins over an increment
//   Good_Cnt  : frames that passed the CRC check
//   Bad_Cnt   : frames that failed the check or were aborted
module tc_crc32_check
  import tc_crc_pkg::*;
#(
  parameter int DATA_LEN = 220,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic             ClkI_Dec8,
  input  logic             Rst_N,
  tc_crc32_check_if.slave  bus,
  input  logic             Clr_Cnt,
  output logic [CNT_W-1:0] Good_Cnt,
  output logic [CNT_W-1:0] Bad_Cnt
);

  localparam logic [7:0] LAST_DATA = 8'(DATA_LEN - 1);
  localparam logic [7:0] LAST_CRC  = 8'(CRC_LEN - 1);
  localparam logic [7:0] LAST_GAP  = 8'(TIMEOUT - 1);

  state_t           state_q,    state_d;
  logic [7:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       gap_cnt_q,  gap_cnt_d;
  logic [31:0]      crc_q,      crc_d;
  logic             en_o_q,     en_o_d;
  logic [7:0]       data_o_q,   data_o_d;
  logic             done_q,     done_d;
  logic             ok_q,       ok_d;
  logic             abort_q,    abort_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q,  bad_cnt_d;
  logic             good_inc,   bad_inc;
  logic [31:0]      crc_next;

  crc32_d8_comb u_crc (
    .crc_i  (crc_q),
    .data_i (bus.DataI),
    .crc_o  (crc_next)
  );

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    crc_d      = crc_q;
    en_o_d     = 1'b0;
    data_o_d   = 8'h00;
    done_d     = 1'b0;
    ok_d       = ok_q;
    abort_d    = 1'b0;
    good_inc   = 1'b0;
    bad_inc    = 1'b0;

    if (bus.En_DataI) begin
      crc_d     = crc_next;
      gap_cnt_d = 8'd0;
      unique case (state_q)
        IDLE: begin
          en_o_d   = 1'b1;
          data_o_d = bus.DataI;
          if (DATA_LEN == 1) begin
            state_d    = CRC;
            byte_cnt_d = 8'd0;
          end else begin
            state_d    = DATA;
            byte_cnt_d = 8'd1;
          end
        end
        DATA: begin
          en_o_d   = 1'b1;
          data_o_d = bus.DataI;
          if (byte_cnt_q == LAST_DATA) begin
            state_d    = CRC;
            byte_cnt_d = 8'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
        CRC: begin
          if (byte_cnt_q == LAST_CRC) begin
            // Residue check: a clean frame plus its CRC leaves zero.
            state_d    = IDLE;
            byte_cnt_d = 8'd0;
            done_d     = 1'b1;
            ok_d       = (crc_next == 32'h0);
            good_inc   = (crc_next == 32'h0);
            bad_inc    = (crc_next != 32'h0);
            crc_d      = CRC_INIT;
          end else begin
            byte_cnt_d = byte_cnt_q + 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      // Idle cycle inside a frame: count towards the abort threshold.
      if (gap_cnt_q == LAST_GAP) begin
        abort_d    = 1'b1;
        bad_inc    = 1'b1;
        state_d    = IDLE;
        byte_cnt_d = 8'd0;
        gap_cnt_d  = 8'd0;
        crc_d      = CRC_INIT;
      end else begin
        gap_cnt_d = gap_cnt_q + 8'd1;
      end
    end
  end

  // Clear wins over a same-cycle increment; increments stop at all-ones.
  always_comb begin
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (Clr_Cnt) begin
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else begin
      if (good_inc && !(&good_cnt_q)) good_cnt_d = good_cnt_q + 1'b1;
      if (bad_inc  && !(&bad_cnt_q))  bad_cnt_d  = bad_cnt_q  + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ClkI_Dec8 or negedge Rst_N) begin
    if (!Rst_N) begin
      state_q    <= IDLE;
      byte_cnt_q <= 8'd0;
      gap_cnt_q  <= 8'd0;
      crc_q      <= CRC_INIT;
      en_o_q     <= 1'b0;
      data_o_q   <= 8'h00;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      abort_q    <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      crc_q      <= crc_d;
      en_o_q     <= en_o_d;
      data_o_q   <= data_o_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      abort_q    <= abort_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign bus.En_DataO    = en_o_q;
  assign bus.DataO       = data_o_q;
  assign bus.Frame_Done  = done_q;
  assign bus.Crc_Ok      = ok_q;
  assign bus.Frame_Abort = abort_q;
  assign Good_Cnt        = good_cnt_q;
  assign Bad_Cnt         = bad_cnt_q;

endmodule

// File: tb/tb_tc_crc32_check.sv
// Self-checking bench for tc_crc32_check.
// dut_a: DATA_LEN=9, 2-bit counters (check-value frame, corruption, saturation, clear).
// dut_b: DATA_LEN=220, TIMEOUT=16 (gaps, timeout, back-to-back, mid-frame reset).
module tb_tc_crc32_check;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en_a, en_b;
  logic [7:0] data_i;
  logic       clr_a, clr_b;
  logic [1:0]  good_a, bad_a;
  logic [15:0] good_b, bad_b;

  always #5 clk = ~clk;

  tc_crc32_check_if a_if ();
  tc_crc32_check_if b_if ();

  assign a_if.En_DataI = en_a;
  assign a_if.DataI    = data_i;
  assign b_if.En_DataI = en_b;
  assign b_if.DataI    = data_i;

  tc_crc32_check #(.DATA_LEN(9), .TIMEOUT(16), .CNT_W(2)) dut_a (
    .ClkI_Dec8 (clk),
    .Rst_N     (rst_n),
    .bus       (a_if.slave),
    .Clr_Cnt   (clr_a),
    .Good_Cnt  (good_a),
    .Bad_Cnt   (bad_a)
  );

  tc_crc32_check #(.DATA_LEN(220), .TIMEOUT(16), .CNT_W(16)) dut_b (
    .ClkI_Dec8 (clk),
    .Rst_N     (rst_n),
    .bus       (b_if.slave),
    .Clr_Cnt   (clr_b),
    .Good_Cnt  (good_b),
    .Bad_Cnt   (bad_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor for dut_b, sampled on the falling edge.
  int         cycle = 0;
  logic [7:0] b_out_q[$];
  int         b_done_cyc[$];
  logic       b_done_ok[$];
  int         b_abort_cnt = 0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (b_if.En_DataO) b_out_q.push_back(b_if.DataO);
    if (b_if.Frame_Done) begin
      b_done_cyc.push_back(cycle);
      b_done_ok.push_back(b_if.Crc_Ok);
    end
    if (b_if.Frame_Abort) b_abort_cnt++;
  end

  // Reference CRC: word-oriented form, byte XORed into the top then 8 shifts.
  function automatic logic [31:0] model_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {d, 24'h0};
    for (int k = 0; k < 8; k++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  logic [7:0] frm[$];
  logic [7:0] payload[$];

  task automatic build_frame(input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frm.delete();
    payload.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 220; i++) begin
      b = 8'((i * seed + 5) ^ (i >> 3));
      frm.push_back(b);
      payload.push_back(b);
      c = model_crc(c, b);
    end
    frm.push_back(c[31:24]);
    frm.push_back(c[23:16]);
    frm.push_back(c[15:8]);
    frm.push_back(c[7:0]);
  endtask

  task automatic drive(input int sel, input logic en, input logic [7:0] d);
    data_i = d;
    en_a   = en && (sel == 0);
    en_b   = en && (sel == 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame_b(input int gap_max);
    for (int i = 0; i < frm.size(); i++) begin
      drive(1, 1'b1, frm[i]);
      if (gap_max > 0) repeat (i % (gap_max + 1)) drive(1, 1'b0, 8'h00);
    end
  endtask

  typedef struct {
    string      name;
    int         flip_idx;
    logic [7:0] flip_mask;
    logic       clr;
    logic       exp_ok;
    logic [1:0] exp_good;
    logic [1:0] exp_bad;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] base_a[13];

  initial begin
    int n_done, n_out, errs;

    base_a = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h03, 8'h76, 8'hE6, 8'hE7};
    vecs[0] = '{"clean",         -1, 8'h00, 1'b0, 1'b1, 2'd1, 2'd0};
    vecs[1] = '{"flip_b5_bit0",   4, 8'h01, 1'b0, 1'b0, 2'd1, 2'd1};
    vecs[2] = '{"flip_crc0_bit7", 9, 8'h80, 1'b0, 1'b0, 2'd1, 2'd2};
    vecs[3] = '{"clean2",        -1, 8'h00, 1'b0, 1'b1, 2'd2, 2'd2};
    vecs[4] = '{"clean3",        -1, 8'h00, 1'b0, 1'b1, 2'd3, 2'd2};
    vecs[5] = '{"good_sat",      -1, 8'h00, 1'b0, 1'b1, 2'd3, 2'd2};
    vecs[6] = '{"flip_last",     12, 8'h01, 1'b0, 1'b0, 2'd3, 2'd3};
    vecs[7] = '{"bad_sat",        0, 8'h80, 1'b0, 1'b0, 2'd3, 2'd3};
    vecs[8] = '{"clr_on_done",   -1, 8'h00, 1'b1, 1'b1, 2'd0, 2'd0};
    vecs[9] = '{"after_clr",     -1, 8'h00, 1'b0, 1'b1, 2'd1, 2'd0};

    // Reset state
    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0; data_i = 8'h00; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) drive(0, 1'b0, 8'h00);
    rst_n = 1'b1;
    drive(0, 1'b0, 8'h00);
    check("rst En_DataO",    {31'd0, a_if.En_DataO}, 0);
    check("rst DataO",       {24'd0, a_if.DataO}, 0);
    check("rst Frame_Done",  {31'd0, a_if.Frame_Done}, 0);
    check("rst Crc_Ok",      {31'd0, a_if.Crc_Ok}, 0);
    check("rst Frame_Abort", {31'd0, a_if.Frame_Abort}, 0);
    check("rst Good_Cnt",    {16'd0, good_b}, 0);
    check("rst Bad_Cnt",     {16'd0, bad_b}, 0);

    // Table-driven 9-byte frames on dut_a
    for (int v = 0; v < 10; v++) begin
      for (int j = 0; j < 13; j++) begin
        logic [7:0] d;
        d = base_a[j] ^ ((j == vecs[v].flip_idx) ? vecs[v].flip_mask : 8'h00);
        clr_a = vecs[v].clr && (j == 12);
        drive(0, 1'b1, d);
        clr_a = 1'b0;
        if (j < 9) begin
          check({vecs[v].name, " En_DataO"}, {31'd0, a_if.En_DataO}, 1);
          check({vecs[v].name, " DataO"},    {24'd0, a_if.DataO}, {24'd0, d});
        end else begin
          check({vecs[v].name, " crc En_DataO"}, {31'd0, a_if.En_DataO}, 0);
          check({vecs[v].name, " crc DataO"},    {24'd0, a_if.DataO}, 0);
        end
        check({vecs[v].name, " Frame_Done"}, {31'd0, a_if.Frame_Done}, (j == 12) ? 1 : 0);
      end
      check({vecs[v].name, " Crc_Ok"},   {31'd0, a_if.Crc_Ok}, {31'd0, vecs[v].exp_ok});
      check({vecs[v].name, " Good_Cnt"}, {30'd0, good_a}, {30'd0, vecs[v].exp_good});
      check({vecs[v].name, " Bad_Cnt"},  {30'd0, bad_a},  {30'd0, vecs[v].exp_bad});
      drive(0, 1'b0, 8'h00);
      check({vecs[v].name, " done pulse"}, {31'd0, a_if.Frame_Done}, 0);
    end

    // 220-byte frame with 0..10 cycle gaps
    build_frame(7);
    b_out_q.delete(); b_done_cyc.delete(); b_done_ok.delete();
    send_frame_b(10);
    repeat (2) drive(1, 1'b0, 8'h00);
    check("gaps En_DataO count", b_out_q.size(), 220);
    errs = 0;
    for (int i = 0; i < 220 && i < b_out_q.size(); i++) if (b_out_q[i] !== payload[i]) errs++;
    check("gaps payload bytes", errs, 0);
    check("gaps done count", b_done_cyc.size(), 1);
    check("gaps Crc_Ok", {31'd0, b_if.Crc_Ok}, 1);
    check("gaps Good_Cnt", {16'd0, good_b}, 1);
    check("gaps no abort", b_abort_cnt, 0);

    // Timeout after byte 100
    build_frame(3);
    n_done = b_done_cyc.size();
    for (int i = 0; i < 100; i++) drive(1, 1'b1, frm[i]);
    repeat (15) drive(1, 1'b0, 8'h00);
    check("to 15 idle no abort", {31'd0, b_if.Frame_Abort}, 0);
    drive(1, 1'b0, 8'h00);
    check("to Frame_Abort", {31'd0, b_if.Frame_Abort}, 1);
    check("to Bad_Cnt", {16'd0, bad_b}, 1);
    check("to Crc_Ok held", {31'd0, b_if.Crc_Ok}, 1);
    drive(1, 1'b0, 8'h00);
    check("to abort pulse", {31'd0, b_if.Frame_Abort}, 0);
    check("to no Frame_Done", b_done_cyc.size(), n_done);
    check("to abort count", b_abort_cnt, 1);
    send_frame_b(0);
    drive(1, 1'b0, 8'h00);
    check("to next frame Crc_Ok", {31'd0, b_if.Crc_Ok}, 1);
    check("to next Good_Cnt", {16'd0, good_b}, 2);

    // Back-to-back frames
    b_done_cyc.delete(); b_done_ok.delete();
    build_frame(11);
    send_frame_b(0);
    build_frame(13);
    send_frame_b(0);
    repeat (2) drive(1, 1'b0, 8'h00);
    check("b2b done count", b_done_cyc.size(), 2);
    if (b_done_cyc.size() == 2) begin
      check("b2b spacing", b_done_cyc[1] - b_done_cyc[0], 224);
      check("b2b ok0", {31'd0, b_done_ok[0]}, 1);
      check("b2b ok1", {31'd0, b_done_ok[1]}, 1);
    end
    check("b2b Good_Cnt", {16'd0, good_b}, 4);

    // Reset mid-frame at byte 50
    build_frame(5);
    for (int i = 0; i < 50; i++) drive(1, 1'b1, frm[i]);
    n_done = b_done_cyc.size();
    n_out  = b_abort_cnt;
    rst_n = 1'b0;
    drive(1, 1'b0, 8'h00);
    check("rst mid En_DataO", {31'd0, b_if.En_DataO}, 0);
    drive(1, 1'b0, 8'h00);
    rst_n = 1'b1;
    repeat (20) drive(1, 1'b0, 8'h00);
    check("rst mid Good_Cnt", {16'd0, good_b}, 0);
    check("rst mid Bad_Cnt", {16'd0, bad_b}, 0);
    check("rst mid Crc_Ok", {31'd0, b_if.Crc_Ok}, 0);
    check("rst mid no done", b_done_cyc.size(), n_done);
    check("rst mid no abort", b_abort_cnt, n_out);
    send_frame_b(0);
    drive(1, 1'b0, 8'h00);
    check("rst then Crc_Ok", {31'd0, b_if.Crc_Ok}, 1);
    check("rst then Good_Cnt", {16'd0, good_b}, 1);
    check("rst then Bad_Cnt", {16'd0, bad_b}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
